// File: rtl/io_bus_arbiter_if.sv
// Client request/ack lines and the shared I/O bus outputs of io_bus_arbiter.
// Handshake: a client raises req with wr/addr/wdata stable and holds it until its ack
// pulses for one cycle; it may drop or change req on the edge that ends that ack cycle.
interface io_bus_arbiter_if;
    logic        req0;
    logic        wr0;
    logic [15:0] addr0;
    logic [7:0]  wdata0;
    logic        ack0;
    logic        req1;
    logic        wr1;
    logic [15:0] addr1;
    logic [7:0]  wdata1;
    logic        ack1;
    logic [7:0]  rdata;
    logic [15:0] addr;
    logic        ior_;
    logic        iow_;
    logic        busy;
    logic        dir;
    logic [2:0]  fsm_state;

    modport master (
        input  req0, wr0, addr0, wdata0, req1, wr1, addr1, wdata1,
        output ack0, ack1, rdata, addr, ior_, iow_, busy, dir, fsm_state
    );

    modport slave (
        output req0, wr0, addr0, wdata0, req1, wr1, addr1, wdata1,
        input  ack0, ack1, rdata, addr, ior_, iow_, busy, dir, fsm_state
    );
endinterface

// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter sharing one 8-bit I/O bus between two clients, with a
// programmable strobe width and a one-cycle ack pulse carrying read data.
module io_bus_arbiter #(
    parameter int unsigned STROBE_CYCLES = 1
) (
    input  logic             clock,
    input  logic             reset,
    io_bus_arbiter_if.master bus,
    inout  wire  [7:0]       data
);
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, ACK} state_t;

    state_t      state, state_next;
    logic        grant_valid;
    logic        grant_id;
    logic        last;
    logic        winner;
    logic        wr_q;
    logic [15:0] addr_q;
    logic [7:0]  wdata_q;
    logic [7:0]  rdata_q;
    logic [3:0]  cnt;
    logic        dir_q;
    logic        ior_q;
    logic        iow_q;
    logic        ack0_q;
    logic        ack1_q;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next  = state;
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        case (state)
            IDLE: begin
                // On a tie the client that did not win last time goes first.
                if (bus.req0 && bus.req1) begin
                    grant_valid = 1'b1;
                    grant_id    = ~last;
                end else if (bus.req0 || bus.req1) begin
                    grant_valid = 1'b1;
                    grant_id    = bus.req1;
                end
                if (grant_valid) state_next = SETUP;
            end
            SETUP:   state_next = STROBE;
            STROBE:  if (cnt == 4'd0) state_next = HOLD;
            HOLD:    state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last    <= 1'b1;
            winner  <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= 16'h0000;
            wdata_q <= 8'h00;
            rdata_q <= 8'h00;
            cnt     <= 4'd0;
            dir_q   <= 1'b0;
            ior_q   <= 1'b1;
            iow_q   <= 1'b1;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        winner  <= grant_id;
                        wr_q    <= grant_id ? bus.wr1    : bus.wr0;
                        addr_q  <= grant_id ? bus.addr1  : bus.addr0;
                        wdata_q <= grant_id ? bus.wdata1 : bus.wdata0;
                        dir_q   <= grant_id ? bus.wr1    : bus.wr0;
                    end
                end
                SETUP: begin
                    if (wr_q) iow_q <= 1'b0;
                    else      ior_q <= 1'b0;
                    cnt <= 4'(STROBE_CYCLES - 1);
                end
                STROBE: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        ior_q <= 1'b1;
                        iow_q <= 1'b1;
                        if (!wr_q) rdata_q <= data;
                    end
                end
                HOLD: begin
                    // addr and write data were held through this cycle; release the bus now.
                    dir_q <= 1'b0;
                    if (winner) ack1_q <= 1'b1;
                    else        ack0_q <= 1'b1;
                end
                ACK: begin
                    last   <= winner;
                    ack0_q <= 1'b0;
                    ack1_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign data          = dir_q ? wdata_q : 8'bz;
    assign bus.ack0      = ack0_q;
    assign bus.ack1      = ack1_q;
    assign bus.rdata     = rdata_q;
    assign bus.addr      = addr_q;
    assign bus.ior_      = ior_q;
    assign bus.iow_      = iow_q;
    assign bus.busy      = (state != IDLE);
    assign bus.dir       = dir_q;
    assign bus.fsm_state = state;
endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed bench for io_bus_arbiter: one instance with a 1-cycle strobe, one with 4.
module tb_io_bus_arbiter;
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_errors;

    io_bus_arbiter_if bus();
    io_bus_arbiter_if bus4();
    wire  [7:0] data;
    wire  [7:0] data4;
    logic [7:0] dev_data;
    logic [7:0] dev_data4;

    // The I/O device answers reads only while the read strobe is low.
    assign data  = (!bus.ior_)  ? dev_data  : 8'bz;
    assign data4 = (!bus4.ior_) ? dev_data4 : 8'bz;

    io_bus_arbiter #(.STROBE_CYCLES(1)) u_dut (
        .clock(clock), .reset(reset), .bus(bus), .data(data)
    );

    io_bus_arbiter #(.STROBE_CYCLES(4)) u_dut4 (
        .clock(clock), .reset(reset), .bus(bus4), .data(data4)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_client(input int id, input logic req, input logic wr,
                              input logic [15:0] a, input logic [7:0] wd);
        if (id == 0) begin
            bus.req0 = req; bus.wr0 = wr; bus.addr0 = a; bus.wdata0 = wd;
        end else begin
            bus.req1 = req; bus.wr1 = wr; bus.addr1 = a; bus.wdata1 = wd;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    logic [0:0] exp_q[$];

    initial begin
        int acks;
        logic [0:0] got_id;
        n_checks = 0;
        n_errors = 0;
        reset = 1'b0;
        dev_data = 8'h00;
        dev_data4 = 8'h00;
        set_client(0, 1'b0, 1'b0, 16'h0, 8'h0);
        set_client(1, 1'b0, 1'b0, 16'h0, 8'h0);
        bus4.req0 = 1'b0; bus4.wr0 = 1'b0; bus4.addr0 = 16'h0; bus4.wdata0 = 8'h0;
        bus4.req1 = 1'b0; bus4.wr1 = 1'b0; bus4.addr1 = 16'h0; bus4.wdata1 = 8'h0;
        @(negedge clock);

        // Reset state
        reset = 1'b1;
        tick();
        tick();
        check("rst_ior", bus.ior_, 1);
        check("rst_iow", bus.iow_, 1);
        check("rst_addr", bus.addr, 16'h0000);
        check("rst_dir", bus.dir, 0);
        check("rst_ack", {bus.ack1, bus.ack0}, 0);
        check("rst_rdata", bus.rdata, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_state", bus.fsm_state, S_IDLE);
        reset = 1'b0;

        // Test 1: client 0 reads 0ABC, device returns 25
        dev_data = 8'h25;
        set_client(0, 1'b1, 1'b0, 16'h0ABC, 8'h00);
        tick();
        check("t1_setup_addr", bus.addr, 16'h0ABC);
        check("t1_setup_ior", bus.ior_, 1);
        check("t1_setup_state", bus.fsm_state, S_SETUP);
        check("t1_setup_dir", bus.dir, 0);
        tick();
        check("t1_strobe_ior", bus.ior_, 0);
        check("t1_strobe_iow", bus.iow_, 1);
        check("t1_strobe_dir", bus.dir, 0);
        tick();
        check("t1_hold_ior", bus.ior_, 1);
        check("t1_hold_ack", bus.ack0, 0);
        check("t1_hold_rdata", bus.rdata, 8'h25);
        tick();
        check("t1_ack0", bus.ack0, 1);
        check("t1_ack1", bus.ack1, 0);
        check("t1_rdata", bus.rdata, 8'h25);
        set_client(0, 1'b0, 1'b0, 16'h0, 8'h0);
        tick();
        check("t1_idle_ack", bus.ack0, 0);
        check("t1_idle_busy", bus.busy, 0);
        check("t1_idle_addr", bus.addr, 16'h0ABC);

        // Test 2: client 1 writes 5A to 0ABD
        set_client(1, 1'b1, 1'b1, 16'h0ABD, 8'h5A);
        tick();
        check("t2_setup_dir", bus.dir, 1);
        check("t2_setup_data", data, 8'h5A);
        check("t2_setup_addr", bus.addr, 16'h0ABD);
        tick();
        check("t2_strobe_iow", bus.iow_, 0);
        check("t2_strobe_ior", bus.ior_, 1);
        check("t2_strobe_data", data, 8'h5A);
        tick();
        check("t2_hold_iow", bus.iow_, 1);
        check("t2_hold_dir", bus.dir, 1);
        check("t2_hold_data", data, 8'h5A);
        tick();
        check("t2_ack1", bus.ack1, 1);
        check("t2_ack0", bus.ack0, 0);
        check("t2_ack_dir", bus.dir, 0);
        check("t2_rdata", bus.rdata, 8'h25);
        set_client(1, 1'b0, 1'b0, 16'h0, 8'h0);
        tick();

        // Test 5: reset while iow_ is low, request still pending afterwards
        set_client(1, 1'b1, 1'b1, 16'h0300, 8'hC3);
        tick();
        tick();
        check("t5_strobe_iow", bus.iow_, 0);
        reset = 1'b1;
        tick();
        check("t5_rst_iow", bus.iow_, 1);
        check("t5_rst_dir", bus.dir, 0);
        check("t5_rst_ack", {bus.ack1, bus.ack0}, 0);
        check("t5_rst_state", bus.fsm_state, S_IDLE);
        reset = 1'b0;
        tick();
        check("t5_regrant", bus.fsm_state, S_SETUP);
        check("t5_regrant_addr", bus.addr, 16'h0300);
        tick();
        tick();
        check("t5_pre_ack", bus.ack1, 0);
        tick();
        check("t5_ack1", bus.ack1, 1);
        set_client(1, 1'b0, 1'b0, 16'h0, 8'h0);
        tick();

        // Test 6: client 0 requests while client 1 is in STROBE
        dev_data = 8'h77;
        set_client(1, 1'b1, 1'b0, 16'h0100, 8'h00);
        tick();
        tick();
        set_client(0, 1'b1, 1'b1, 16'h0101, 8'h99);
        tick();
        check("t6_hold_rdata", bus.rdata, 8'h77);
        tick();
        check("t6_ack1", bus.ack1, 1);
        check("t6_no_ack0", bus.ack0, 0);
        set_client(1, 1'b0, 1'b0, 16'h0, 8'h0);
        tick();
        check("t6_idle", bus.fsm_state, S_IDLE);
        tick();
        check("t6_grant0", bus.fsm_state, S_SETUP);
        check("t6_grant0_addr", bus.addr, 16'h0101);
        tick();
        tick();
        tick();
        check("t6_ack0", bus.ack0, 1);
        set_client(0, 1'b0, 1'b0, 16'h0, 8'h0);
        tick();

        // Test 3: both clients request continuously from reset; scoreboard on grant order
        do_reset();
        exp_q = '{1'b0, 1'b1, 1'b0, 1'b1};
        set_client(0, 1'b1, 1'b1, 16'h1000, 8'hA0);
        set_client(1, 1'b1, 1'b1, 16'h1001, 8'hA1);
        acks = 0;
        for (int cyc = 0; cyc < 40 && acks < 4; cyc++) begin
            tick();
            check("t3_dual_ack", bus.ack0 & bus.ack1, 0);
            if (bus.ack0 || bus.ack1) begin
                got_id = bus.ack1;
                check("t3_order", got_id, (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx);
                acks++;
                if (acks == 4) begin
                    set_client(0, 1'b0, 1'b0, 16'h0, 8'h0);
                    set_client(1, 1'b0, 1'b0, 16'h0, 8'h0);
                end
                tick();
                check("t3_idle_gap", bus.busy, 0);
                if (acks < 4) begin
                    tick();
                    check("t3_regrant", bus.fsm_state, S_SETUP);
                end
            end
        end
        check("t3_txn_count", acks, 4);

        // Test 4: 4-cycle strobe read; device data changes every cycle
        bus4.req0 = 1'b1; bus4.wr0 = 1'b0; bus4.addr0 = 16'h0200;
        for (int k = 1; k <= 7; k++) begin
            tick();
            dev_data4 = 8'h40 + 8'(k);
            check($sformatf("t4_ior_c%0d", k), bus4.ior_, (k >= 2 && k <= 5) ? 0 : 1);
            check($sformatf("t4_iow_c%0d", k), bus4.iow_, 1);
            check($sformatf("t4_ack_c%0d", k), bus4.ack0, (k == 7) ? 1 : 0);
            if (k == 7) bus4.req0 = 1'b0;
        end
        check("t4_rdata", bus4.rdata, 8'h45);
        tick();
        check("t4_idle", bus4.busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
